// File: rtl/key_cmd_arbiter.sv
// Turns debounced left/right key levels into press and auto-repeat move commands.
// Both keys share one valid/ready command channel, with round-robin between them.
module key_cmd_arbiter #(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 32
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       left_flag,
  input  logic       right_flag,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic       cmd_dir,
  output logic       cmd_rep,
  output logic [7:0] drop_cnt
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_HOLD = 2'd1;
  localparam logic [1:0] S_REPEAT    = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

  // Index 0 is the left key, index 1 the right key throughout.
  logic [1:0]            w_flag;
  logic [1:0]            r_flag_d;
  logic [1:0][1:0]       r_state;
  logic [1:0][CNT_W-1:0] r_cnt;
  logic [1:0][1:0]       w_state_nx;
  logic [1:0][CNT_W-1:0] w_cnt_nx;
  logic [1:0]            w_press;
  logic [1:0]            w_ev;
  logic [1:0]            w_ev_rep;

  logic [1:0]            r_pend_v;
  logic [1:0]            r_pend_rep;
  logic                  r_rr;
  logic                  w_load;
  logic                  w_both;
  logic [1:0]            w_grant;
  logic [1:0]            w_drop;
  logic [1:0]            w_drop_sum;

  logic                  r_cmd_valid;
  logic                  r_cmd_dir;
  logic                  r_cmd_rep;
  logic [7:0]            r_drop_cnt;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_flag  = {right_flag, left_flag};
  assign w_press = w_flag & ~r_flag_d;

  // Per-key press/hold/repeat sequencing
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_ev[k]       = 1'b0;
      w_ev_rep[k]   = 1'b0;
      w_state_nx[k] = r_state[k];
      w_cnt_nx[k]   = r_cnt[k];
      case (r_state[k])
        S_IDLE: begin
          if (w_press[k]) begin
            w_ev[k]       = 1'b1;
            w_cnt_nx[k]   = CNT_ZERO;
            w_state_nx[k] = S_WAIT_HOLD;
          end
        end
        S_WAIT_HOLD: begin
          if (!w_flag[k]) begin
            w_cnt_nx[k]   = CNT_ZERO;
            w_state_nx[k] = S_IDLE;
          end else if (r_cnt[k] == HOLD_LAST) begin
            w_ev[k]       = 1'b1;
            w_ev_rep[k]   = 1'b1;
            w_cnt_nx[k]   = CNT_ZERO;
            w_state_nx[k] = S_REPEAT;
          end else begin
            w_cnt_nx[k]   = r_cnt[k] + CNT_ONE;
          end
        end
        S_REPEAT: begin
          if (!w_flag[k]) begin
            w_cnt_nx[k]   = CNT_ZERO;
            w_state_nx[k] = S_IDLE;
          end else if (r_cnt[k] == REPEAT_LAST) begin
            w_ev[k]       = 1'b1;
            w_ev_rep[k]   = 1'b1;
            w_cnt_nx[k]   = CNT_ZERO;
          end else begin
            w_cnt_nx[k]   = r_cnt[k] + CNT_ONE;
          end
        end
        default: begin
          w_cnt_nx[k]   = CNT_ZERO;
          w_state_nx[k] = S_IDLE;
        end
      endcase
    end
  end

  // The output slot may take a new command when empty or when it is being consumed.
  assign w_load = ~r_cmd_valid | cmd_ready;
  assign w_both = &r_pend_v;

  always_comb begin
    w_grant = 2'b00;
    if (w_load) begin
      if (w_both) w_grant = r_rr ? 2'b10 : 2'b01;
      else        w_grant = r_pend_v;
    end
  end

  // A slot being granted this cycle can absorb a new event without loss.
  assign w_drop     = w_ev & r_pend_v & ~w_grant;
  assign w_drop_sum = {1'b0, w_drop[0]} + {1'b0, w_drop[1]};

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_flag_d    <= 2'b00;
      r_state     <= {S_IDLE, S_IDLE};
      r_cnt       <= '0;
      r_pend_v    <= 2'b00;
      r_pend_rep  <= 2'b00;
      r_rr        <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_dir   <= 1'b0;
      r_cmd_rep   <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_flag_d <= w_flag;
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      for (int k = 0; k < 2; k++) begin
        if (w_ev[k] && !w_drop[k]) begin
          r_pend_v[k]   <= 1'b1;
          r_pend_rep[k] <= w_ev_rep[k];
        end else if (w_grant[k]) begin
          r_pend_v[k]   <= 1'b0;
        end
      end
      if (w_load) begin
        r_cmd_valid <= |w_grant;
        if (|w_grant) begin
          r_cmd_dir <= w_grant[1];
          r_cmd_rep <= r_pend_rep[w_grant[1]];
        end
      end
      if (w_load && w_both) r_rr <= ~r_rr;
      r_drop_cnt <= sat_add8(r_drop_cnt, w_drop_sum);
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_dir   = r_cmd_dir;
  assign cmd_rep   = r_cmd_rep;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Testbench for key_cmd_arbiter: vector table, directed corner sequences and
// randomized traffic compared every cycle against an age-based reference model.
module tb_key_cmd_arbiter;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b0, left_flag = 1'b0, right_flag = 1'b0, cmd_ready = 1'b0;
  logic       cmd_valid, cmd_dir, cmd_rep;
  logic [7:0] drop_cnt;
  int         checks = 0;
  int         errors = 0;

  key_cmd_arbiter #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP), .CNT_W(32)) dut (
    .clk_50m(clk_50m), .rst(rst), .left_flag(left_flag), .right_flag(right_flag),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_rep(cmd_rep),
    .drop_cnt(drop_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  // Reference model: each key tracks how long it has been held since its press.
  bit m_prev[2], m_held[2], m_pv[2], m_pr[2];
  int m_age[2];
  bit m_ov, m_od, m_or, m_ptr;
  int m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit fl_l, input bit fl_r, input bit rdy);
    bit fl[2], ev[2], er[2], gr[2], opv[2];
    int g, nd;
    if (r) begin
      m_prev = '{0, 0}; m_held = '{0, 0}; m_pv = '{0, 0}; m_pr = '{0, 0};
      m_age = '{0, 0}; m_ov = 0; m_od = 0; m_or = 0; m_ptr = 0; m_drop = 0;
      return;
    end
    fl[0] = fl_l; fl[1] = fl_r;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 0; er[k] = 0;
      if (fl[k] && !m_prev[k]) begin
        m_held[k] = 1; m_age[k] = 0; ev[k] = 1;
      end else if (fl[k] && m_held[k]) begin
        m_age[k]++;
        if (m_age[k] >= HOLD && (m_age[k] - HOLD) % REP == 0) begin
          ev[k] = 1; er[k] = 1;
        end
      end
      if (!fl[k]) m_held[k] = 0;
      m_prev[k] = fl[k];
    end
    opv = m_pv; gr = '{0, 0};
    if (!m_ov || rdy) begin
      g = -1;
      if (opv[0] && opv[1]) begin g = int'(m_ptr); m_ptr = !m_ptr; end
      else if (opv[0]) g = 0;
      else if (opv[1]) g = 1;
      if (g >= 0) begin
        m_ov = 1; m_od = (g == 1); m_or = m_pr[g]; m_pv[g] = 0; gr[g] = 1;
      end else begin
        m_ov = 0;
      end
    end
    nd = 0;
    for (int k = 0; k < 2; k++) begin
      if (ev[k]) begin
        if (opv[k] && !gr[k]) nd++;
        else begin m_pv[k] = 1; m_pr[k] = er[k]; end
      end
    end
    m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
  endtask

  task automatic tick();
    @(posedge clk_50m);
    model_step(rst, left_flag, right_flag, cmd_ready);
    #1;
    check("model_valid", cmd_valid, m_ov);
    if (m_ov) begin
      check("model_dir", cmd_dir, m_od);
      check("model_rep", cmd_rep, m_or);
    end
    check("model_drop", drop_cnt, m_drop);
  endtask

  typedef struct {
    bit rst, l, r, rdy;
    bit ev, ed, er;
    int edrop;
  } vec_t;

  vec_t tbl[15];
  int   offs[$];
  bit   reps[$];
  int   deliv;

  initial begin
    // Single press, then two simultaneous presses showing the round-robin flip.
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 1, 1, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; left_flag = tbl[i].l; right_flag = tbl[i].r; cmd_ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), cmd_valid, tbl[i].ev);
      if (tbl[i].ev || tbl[i].rst) begin
        check($sformatf("vec%0d_dir", i), cmd_dir, tbl[i].ed);
        check($sformatf("vec%0d_rep", i), cmd_rep, tbl[i].er);
      end
      check($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].edrop);
    end

    // Right held 20 cycles: press command, then repeats 8, 12, 16 cycles later.
    cmd_ready = 1; right_flag = 1;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) right_flag = 0;
      tick();
      if (cmd_valid) begin
        offs.push_back(c); reps.push_back(cmd_rep);
        check("hold_dir", cmd_dir, 1);
      end
    end
    check("hold_count", offs.size(), 4);
    if (offs.size() == 4) begin
      check("hold_off0", offs[0], 1);  check("hold_rep0", reps[0], 0);
      check("hold_off1", offs[1], 9);  check("hold_rep1", reps[1], 1);
      check("hold_off2", offs[2], 13); check("hold_rep2", reps[2], 1);
      check("hold_off3", offs[3], 17); check("hold_rep3", reps[3], 1);
    end

    // Consumer stalled: three left presses, third one overflows its pending slot.
    cmd_ready = 0;
    for (int p = 0; p < 3; p++) begin
      left_flag = 1; tick();
      left_flag = 0; tick(); tick();
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_valid", cmd_valid, 1);
      check("stall_dir", cmd_dir, 0);
      check("stall_rep", cmd_rep, 0);
    end
    check("stall_drop", drop_cnt, 1);
    cmd_ready = 1; deliv = 0;
    for (int c = 0; c < 6; c++) begin
      if (cmd_valid) deliv++;
      tick();
    end
    check("stall_delivered", deliv, 2);

    // Reset while left is auto-repeating.
    left_flag = 1;
    for (int c = 0; c < 12; c++) tick();
    rst = 1; tick(); rst = 0;
    check("rst_valid", cmd_valid, 0);
    check("rst_dir", cmd_dir, 0);
    check("rst_rep", cmd_rep, 0);
    check("rst_drop", drop_cnt, 0);
    tick(); check("post_rst_c1", cmd_valid, 0);
    tick(); check("post_rst_c2", cmd_valid, 1);
    check("post_rst_dir", cmd_dir, 0);
    check("post_rst_rep", cmd_rep, 0);
    tick(); check("post_rst_c3", cmd_valid, 0);

    // Forced overflows with both keys while the consumer is stalled.
    cmd_ready = 0; left_flag = 0; right_flag = 0; tick();
    for (int p = 0; p < 160; p++) begin
      left_flag = 1; right_flag = 1; tick();
      left_flag = 0; right_flag = 0; tick();
    end
    check("drop_sat", drop_cnt, 255);
    left_flag = 1; right_flag = 1; tick();
    left_flag = 0; right_flag = 0; tick();
    check("drop_sat_hold", drop_cnt, 255);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) left_flag = ~left_flag;
      if ($urandom_range(0, 11) == 0) right_flag = ~right_flag;
      cmd_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
